// File: rtl/fma_mul_resp.sv
// fma_mul_resp: 27x27 unsigned mantissa multiplier responder, stallable 2-stage pipeline.
// Define FMA_MUL_RESP_OREG_EN to add an output register stage (latency 3).
module fma_mul_resp #(
    parameter int AW    = 27,
    parameter int BW    = 27,
    parameter int SPLIT = 14
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             req,
    input  logic [AW-1:0]    req_in_1,
    input  logic [BW-1:0]    req_in_2,
    output logic [AW+BW-1:0] out,
    output logic             vld
);

    localparam int PW = AW + BW;
    localparam int LW = AW + SPLIT;
    localparam int HW = AW + BW - SPLIT;

    logic [LW-1:0] plo_q, plo_d;
    logic [HW-1:0] phi_q, phi_d;
    logic          va_q, va_d;
    logic [PW-1:0] out_b_q, out_b_d;
    logic          vld_b_q, vld_b_d;

    always_comb begin
        plo_d   = plo_q;
        phi_d   = phi_q;
        va_d    = va_q;
        out_b_d = out_b_q;
        vld_b_d = vld_b_q;
        if (en) begin
            plo_d   = LW'(req_in_1) * LW'(req_in_2[SPLIT-1:0]);
            phi_d   = HW'(req_in_1) * HW'(req_in_2[BW-1:SPLIT]);
            va_d    = req;
            // Recombine the two partial products at the split point
            out_b_d = PW'(plo_q) + (PW'(phi_q) << SPLIT);
            vld_b_d = va_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            plo_q   <= '0;
            phi_q   <= '0;
            va_q    <= 1'b0;
            out_b_q <= '0;
            vld_b_q <= 1'b0;
        end else begin
            plo_q   <= plo_d;
            phi_q   <= phi_d;
            va_q    <= va_d;
            out_b_q <= out_b_d;
            vld_b_q <= vld_b_d;
        end
    end

`ifdef FMA_MUL_RESP_OREG_EN
    logic [PW-1:0] out_c_q, out_c_d;
    logic          vld_c_q, vld_c_d;

    always_comb begin
        out_c_d = out_c_q;
        vld_c_d = vld_c_q;
        if (en) begin
            out_c_d = out_b_q;
            vld_c_d = vld_b_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_c_q <= '0;
            vld_c_q <= 1'b0;
        end else begin
            out_c_q <= out_c_d;
            vld_c_q <= vld_c_d;
        end
    end

    assign out = out_c_q;
    assign vld = vld_c_q;
`else
    assign out = out_b_q;
    assign vld = vld_b_q;
`endif

endmodule

// File: tb/tb_fma_mul_resp.sv
// Scoreboard bench for fma_mul_resp: expected products are queued with the
// enabled-edge count at which they must appear; a negedge monitor checks them.
module tb_fma_mul_resp;

`ifdef FMA_MUL_RESP_OREG_EN
    localparam int DEPTH = 3;
`else
    localparam int DEPTH = 2;
`endif

    logic        clk = 1'b0;
    logic        reset, en, req;
    logic [26:0] a, b;
    logic [53:0] out;
    logic        vld;

    always #5 clk = ~clk;

    fma_mul_resp dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .req      (req),
        .req_in_1 (a),
        .req_in_2 (b),
        .out      (out),
        .vld      (vld)
    );

    typedef struct {
        logic [53:0] prod;
        int          due;
    } item_t;

    item_t       sb[$];
    item_t       it;
    int          en_cnt = 0;
    bit          last_en = 1'b0;
    bit          rst_edge = 1'b0;
    int          checks = 0;
    int          errors = 0;
    bit          exp_vld = 1'b0;
    logic [53:0] exp_out = '0;
    logic [63:0] full;

    // Reference model: count enabled edges; an accepted request is due
    // DEPTH-1 enabled edges after the edge that accepted it.
    always @(posedge clk) begin
        rst_edge = reset;
        last_en  = en & ~reset;
        if (reset) begin
            sb.delete();
        end else if (en) begin
            en_cnt++;
            if (req) begin
                full = 64'(a) * 64'(b);
                sb.push_back('{prod: full[53:0], due: en_cnt + DEPTH - 1});
            end
        end
    end

    always @(negedge clk) begin
        if (rst_edge) begin
            checks += 2;
            if (vld !== 1'b0) begin
                errors++;
                $display("FAIL reset_vld got %b want 0", vld);
            end
            if (out !== 54'd0) begin
                errors++;
                $display("FAIL reset_out got %h want 0", out);
            end
            exp_vld = 1'b0;
            exp_out = '0;
        end else if (last_en) begin
            checks++;
            if (sb.size() > 0 && sb[0].due == en_cnt) begin
                it = sb.pop_front();
                if (vld !== 1'b1 || out !== it.prod) begin
                    errors++;
                    $display("FAIL result vld=%b out=%h want vld=1 out=%h",
                             vld, out, it.prod);
                end
                exp_vld = 1'b1;
                exp_out = it.prod;
            end else begin
                if (vld !== 1'b0) begin
                    errors++;
                    $display("FAIL spurious_vld got %b want 0 out=%h", vld, out);
                end
                exp_vld = 1'b0;
            end
        end else begin
            checks++;
            if (vld !== exp_vld || (exp_vld && out !== exp_out)) begin
                errors++;
                $display("FAIL stall_hold vld=%b out=%h want vld=%b out=%h",
                         vld, out, exp_vld, exp_out);
            end
        end
    end

    task automatic step(input bit r, input bit e, input bit q,
                        input logic [26:0] x, input logic [26:0] y);
        reset = r;
        en    = e;
        req   = q;
        a     = x;
        b     = y;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, 27'd0, 27'd0);
    endtask

    function automatic logic [26:0] pick();
        case ($urandom_range(4))
            0: return 27'h7FFFFFF;
            1: return 27'd0;
            2: return 27'd1 << $urandom_range(26);
            default: return 27'($urandom);
        endcase
    endfunction

    localparam logic [26:0] M = 27'h7FFFFFF;

    initial begin
        reset = 1'b1;
        en    = 1'b0;
        req   = 1'b0;
        a     = '0;
        b     = '0;
        step(1'b1, 1'b0, 1'b0, 27'd0, 27'd0);
        step(1'b1, 1'b1, 1'b0, 27'd0, 27'd0);
        // single request
        step(1'b0, 1'b1, 1'b1, 27'd3, 27'd5);
        idle(4);
        // max operands and split-boundary carry
        step(1'b0, 1'b1, 1'b1, M, M);
        step(1'b0, 1'b1, 1'b1, 27'h4000, 27'h2000);
        idle(3);
        // back-to-back
        step(1'b0, 1'b1, 1'b1, 27'd1, 27'd1);
        step(1'b0, 1'b1, 1'b1, M, 27'd1);
        step(1'b0, 1'b1, 1'b1, 27'h2000, 27'h4000);
        step(1'b0, 1'b1, 1'b1, 27'd0, 27'h5555555);
        idle(3);
        // stall with req held high while disabled
        step(1'b0, 1'b1, 1'b1, 27'd7, 27'd9);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 27'd11, 27'd13);
        idle(4);
        // bubble
        step(1'b0, 1'b1, 1'b1, 27'd6, 27'd7);
        step(1'b0, 1'b1, 1'b0, 27'd100, 27'd100);
        step(1'b0, 1'b1, 1'b1, 27'h123456, 27'h654321);
        idle(3);
        // reset mid-flight
        step(1'b0, 1'b1, 1'b1, 27'd5, 27'd6);
        step(1'b0, 1'b1, 1'b1, 27'd8, 27'd9);
        step(1'b1, 1'b1, 1'b1, 27'd2, 27'd2);
        idle(4);
        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(99) == 0, $urandom_range(9) < 8,
                 $urandom_range(9) < 6, pick(), pick());
        end
        idle(6);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
